// File: rtl/serial_encode.sv
// Thermostat frame transmitter: host-loaded payload registers serialised as one
// 192-bit BEP frame on serial_data/serial_clock, MSB first.
module serial_encode #(
   parameter int unsigned CLOCK_DIV = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       write_enable,
   input  logic [3:0] address,
   input  logic [7:0] write_data,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       serial_clock,
   output logic       serial_data
);

   localparam int unsigned FRAME_BITS = 192;
   localparam int unsigned CNT_W      = 8;

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLOCK_DIV - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   localparam logic [31:0] PREAMBLE  = 32'hAAAA_AAAA;
   localparam logic [15:0] FRAME_TYP = 16'hD391;
   localparam logic [31:0] CONST_FLD = 32'h0DFF_FFFE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   logic [31:0] thermostat_id_q;
   logic [15:0] room_temp_q;
   logic [15:0] set_temp_q;
   logic [7:0]  state_byte_q;
   logic [7:0]  tail_1_q;
   logic [7:0]  tail_2_q;
   logic [7:0]  tail_3_q;

   state_t                 state_q, state_d;
   logic [FRAME_BITS-1:0]  shift_q, shift_d;
   logic [CNT_W-1:0]       bit_q, bit_d;
   logic [CNT_W-1:0]       div_q, div_d;
   logic                   busy_d, done_d, sclk_d, sdata_d;
   logic [FRAME_BITS-1:0]  frame_c;

   // Payload register file; addresses 12..15 are unmapped.
   always_ff @(posedge clock) begin
      if (!reset) begin
         thermostat_id_q <= '0;
         room_temp_q     <= '0;
         set_temp_q      <= '0;
         state_byte_q    <= '0;
         tail_1_q        <= '0;
         tail_2_q        <= '0;
         tail_3_q        <= '0;
      end else if (write_enable) begin
         case (address)
            4'd0:    thermostat_id_q[7:0]   <= write_data;
            4'd1:    thermostat_id_q[15:8]  <= write_data;
            4'd2:    thermostat_id_q[23:16] <= write_data;
            4'd3:    thermostat_id_q[31:24] <= write_data;
            4'd4:    room_temp_q[7:0]       <= write_data;
            4'd5:    room_temp_q[15:8]      <= write_data;
            4'd6:    set_temp_q[7:0]        <= write_data;
            4'd7:    set_temp_q[15:8]       <= write_data;
            4'd8:    state_byte_q           <= write_data;
            4'd9:    tail_1_q               <= write_data;
            4'd10:   tail_2_q               <= write_data;
            4'd11:   tail_3_q               <= write_data;
            default: ;
         endcase
      end
   end

   // Registered payload only, so a same-cycle write misses the snapshot.
   assign frame_c = {PREAMBLE, FRAME_TYP, FRAME_TYP, CONST_FLD,
                     thermostat_id_q, room_temp_q, set_temp_q, state_byte_q,
                     tail_1_q, tail_2_q, tail_3_q};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_q        <= '0;
         div_q        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         serial_clock <= 1'b0;
         serial_data  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         div_q        <= div_d;
         busy         <= busy_d;
         done         <= done_d;
         serial_clock <= sclk_d;
         serial_data  <= sdata_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register in step.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      div_d   = div_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = frame_c;
               bit_d   = '0;
               div_d   = '0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = HIGH;
            end else begin
               div_d = div_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (bit_q == LAST_BIT) begin
                  state_d = DONE;
               end else begin
                  shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                  bit_d   = bit_q + CNT_W'(1);
                  state_d = LOW;
               end
            end else begin
               div_d = div_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d  = (state_d == LOW) || (state_d == HIGH);
      done_d  = (state_d == DONE);
      sclk_d  = (state_d == HIGH);
      sdata_d = busy_d && shift_d[FRAME_BITS-1];
   end

endmodule

// File: doc/serial_encode.md
Name: serial_encode

Overview:
- Transmit-side counterpart of the thermostat frame receiver.
- A host loads payload bytes through an 8-bit addressed write port, then pulses start.
- The block serialises one 192-bit BEP thermostat frame on serial_data / serial_clock, inserting the fixed preamble, type and constant fields.
- Used to emulate a thermostat and as a loopback source for the decode path.

Parameters:
- CLOCK_DIV, 4, clock cycles per serial_clock half-period; legal range 1..255.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- write_enable  input  1  when 1, write_data is stored at address this cycle.
- address  input  4  payload register select.
- write_data  input  8  payload byte.
- start  input  1  single-cycle request to transmit one frame.
- busy  output  1  1 while a frame is in flight.
- done  output  1  one-cycle pulse after the last bit.
- serial_clock  output  1  generated bit clock; idles low.
- serial_data  output  1  frame bit, MSB first.

Behaviour:
- Payload registers:
  - address 0..3: thermostat_id[7:0], [15:8], [23:16], [31:24].
  - 4, 5: room_temp low, high byte. 6, 7: set_temp low, high byte.
  - 8: state. 9, 10, 11: tail_1, tail_2, tail_3.
  - Addresses 12..15: writes ignored.
  - All payload registers reset to 0.
  - Writes are accepted in any state, including while busy.
- Frame order, 192 bits, each field MSB first:
  - preamble 32'hAAAAAAAA, type_1 16'hD391, type_2 16'hD391, constant 32'h0DFFFFFE.
  - Then thermostat_id[31:0], room_temp[15:0], set_temp[15:0], state[7:0], tail_1, tail_2, tail_3.
- Snapshot: on an accepted start, the full 192-bit frame is loaded into a shift register. Later payload writes do not affect the frame in flight.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - Outputs: serial_clock=0, serial_data=0, busy=0.
  - start=1 -> load shift register, bit_count=0, div_count=0, go to LOW. busy=1 from the next cycle.
  - If write_enable and start occur in the same cycle, the write is NOT included in the snapshot.
- LOW:
  - serial_clock=0; serial_data = current bit (shift register MSB).
  - After CLOCK_DIV cycles -> HIGH.
- HIGH:
  - serial_clock=1; serial_data unchanged. The receiver samples on the serial_clock rising edge.
  - After CLOCK_DIV cycles: if bit_count==191 -> DONE. Otherwise shift left by 1, bit_count+1, go to LOW. serial_data changes only coincident with serial_clock falling.
- DONE:
  - busy=0, done=1, serial_clock=0, serial_data=0 for exactly one cycle, then IDLE.
  - A start asserted during DONE is ignored.
- Timing:
  - start sampled at cycle t -> busy high for cycles t+1 .. t+192*2*CLOCK_DIV; done high at t+192*2*CLOCK_DIV+1.
  - CLOCK_DIV=4: 1536 busy cycles, done at t+1537.
  - Earliest next accepted start: the cycle after done.
- start while busy, or in DONE: ignored; not queued; no effect on the current frame.
- Counters: div_count is an 8-bit counter that wraps to 0 at each phase change. bit_count is 8 bits, range 0..191, never wraps past 191.
- Reset (reset=0) in any state, including mid-frame:
  - Next cycle: IDLE, busy=0, done=0, serial_clock=0, serial_data=0.
  - Shift register, counters and all payload registers cleared.
  - A partial frame is simply truncated; no completion pulse.
- Reset values of outputs: busy=0, done=0, serial_clock=0, serial_data=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> busy=0, done=0, serial_clock=0, serial_data=0 throughout; no frame starts.
- Frame content:
  - Write id 0x12345678, room_temp 0x00D2, set_temp 0x00C8, state 0x03, tails 0x11/0x22/0x33, then pulse start (CLOCK_DIV=4).
  - Collect serial_data on 192 serial_clock rising edges.
  - Required bits: AAAAAAAA D391 D391 0DFFFFFE 12345678 00D2 00C8 03 11 22 33.
  - busy high for 1536 cycles; done pulses once at t+1537.
- Edge alignment: for every bit, serial_data is stable for the whole HIGH phase and changes only on serial_clock falling edges. Each phase lasts exactly 4 cycles.
- Snapshot and ignored start:
  - Mid-frame, write room_temp low=0xFF and pulse start -> current frame still carries 00D2; no second frame.
  - Next start after done -> frame carries 00FF.
- Reset mid-frame: assert reset at bit 100 -> serial_clock and serial_data 0 next cycle, busy=0, no done pulse; the following frame sends all-zero payload after the fixed fields.
- Loopback with CLOCK_DIV=1 into the receive path: after the frame, receiver address 0..3 reads 0xD2, 0x00, 0xC8, 0x00.
